// File: rtl/guess_fifo.sv
// -----------------------------------------------------------------------------
// guess_fifo
//
// Small show-ahead FIFO that sits between a byte receiver and a game engine.
// Each rising edge of the receiver's byte-valid level pushes one byte. A byte
// is dropped if it is not a letter (when FILTER=1) or if the FIFO is full.
// With FILTER=1, letters are folded to upper case before they are stored.
// The consumer pops the head entry by raising game_rdy while guess_valid is 1.
//
// Parameters
//   WIDTH   data width of received bytes and stored guesses (8 when FILTER=1)
//   DEPTH   number of storage entries, power of two, >= 2
//   FILTER  1 = accept ASCII letters only, folded to upper case
//           0 = accept every byte unchanged
//
// Ports
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   ready        receiver byte-valid level (may stay high for several cycles)
//   Rx_byte      received byte, sampled on the push edge
//   game_rdy     consumer ready; pops when guess_valid is also 1
//   flush        synchronous clear of all stored entries
//   guess        head entry (show-ahead), zero when empty
//   guess_valid  at least one entry stored
//   full         count == DEPTH
//   count        number of stored entries
//   overflow     one-cycle pulse: push dropped because the FIFO was full
//   reject       one-cycle pulse: push dropped by the letter filter
// -----------------------------------------------------------------------------
module guess_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int FILTER = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ready,
  input  logic [WIDTH-1:0]             Rx_byte,
  input  logic                         game_rdy,
  input  logic                         flush,
  output logic [WIDTH-1:0]             guess,
  output logic                         guess_valid,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         reject
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // ASCII letter bounds and the case-fold offset.
  localparam logic [WIDTH-1:0] UC_A     = WIDTH'(8'h41);
  localparam logic [WIDTH-1:0] UC_Z     = WIDTH'(8'h5A);
  localparam logic [WIDTH-1:0] LC_A     = WIDTH'(8'h61);
  localparam logic [WIDTH-1:0] LC_Z     = WIDTH'(8'h7A);
  localparam logic [WIDTH-1:0] CASE_OFS = WIDTH'(8'h20);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             ready_q;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic             push_evt;   // rising edge of ready
  logic             accept;     // byte passes the filter
  logic [WIDTH-1:0] data_in;    // byte as it will be stored
  logic             pop;
  logic             do_write;

  assign push_evt = ready & ~ready_q;

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    accept  = 1'b1;
    data_in = Rx_byte;
    if (FILTER != 0) begin
      if ((Rx_byte >= UC_A) && (Rx_byte <= UC_Z)) begin
        accept = 1'b1;
      end else if ((Rx_byte >= LC_A) && (Rx_byte <= LC_Z)) begin
        data_in = Rx_byte - CASE_OFS;
      end else begin
        accept = 1'b0;
      end
    end
  end

  // A pop frees the slot on the same edge, so a push into a full FIFO that
  // coincides with a pop is still stored.
  assign pop      = game_rdy & guess_valid & ~flush;
  assign do_write = push_evt & accept & (~full | pop) & ~flush;

  // ---------------------------------------------------------------------------
  // Pointers, count, status pulses
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // ready_q starts high so a ready already asserted at reset release is
      // not mistaken for a fresh byte.
      ready_q  <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      reject   <= 1'b0;
    end else begin
      ready_q  <= ready;
      overflow <= 1'b0;
      reject   <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_write) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (do_write && !pop) begin
          count <= count + CNT_ONE;
        end else if (!do_write && pop) begin
          count <= count - CNT_ONE;
        end
        // A filtered byte never reaches the full check, so reject wins.
        reject   <= push_evt & ~accept;
        overflow <= push_evt & accept & full & ~pop;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; its contents are only observed through
  // guess, which is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registers only
  // ---------------------------------------------------------------------------
  assign guess_valid = (count != '0);
  assign full        = (count == CNT_FULL);
  assign guess       = guess_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_guess_fifo.sv
// -----------------------------------------------------------------------------
// tb_guess_fifo
//
// Directed bench for guess_fifo (WIDTH=8, DEPTH=4, FILTER=1). Inputs change
// and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_guess_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             tb_clk;
  logic             rst;
  logic             ready;
  logic [WIDTH-1:0] Rx_byte;
  logic             game_rdy;
  logic             flush;
  logic [WIDTH-1:0] guess;
  logic             guess_valid;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             reject;

  int checks = 0;
  int errors = 0;

  guess_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FILTER(1)) dut (
    .clk        (tb_clk),
    .rst        (rst),
    .ready      (ready),
    .Rx_byte    (Rx_byte),
    .game_rdy   (game_rdy),
    .flush      (flush),
    .guess      (guess),
    .guess_valid(guess_valid),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .reject     (reject)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  // One push: ready high for one edge, then low for one edge. Pulses are
  // sampled right after the push edge.
  task automatic push(input logic [7:0] b, output logic ov, output logic rj);
    Rx_byte = b;
    ready   = 1'b1;
    step();
    ov    = overflow;
    rj    = reject;
    ready = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; Rx_byte = 8'h41; game_rdy = 1'b0; flush = 1'b0;
    step();
    step();
    checks++;
    if (count !== 3'd0 || guess_valid !== 1'b0 || full !== 1'b0 ||
        guess !== 8'h00 || overflow !== 1'b0 || reject !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d gv=%b full=%b guess=%h ov=%b rj=%b required all 0",
               count, guess_valid, full, guess, overflow, reject);
    end
    rst = 1'b0;
    repeat (5) step();
    checks++;
    if (count !== 3'd0 || guess_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_ready: count=%0d gv=%b required 0 0", count, guess_valid);
    end
    ready = 1'b0;
    step();
    // game_rdy while empty changes nothing
    game_rdy = 1'b1;
    step();
    step();
    game_rdy = 1'b0;
    checks++;
    if (count !== 3'd0 || guess_valid !== 1'b0 || guess !== 8'h00) begin
      errors++;
      $display("FAIL pop_when_empty: count=%0d gv=%b guess=%h required 0 0 00",
               count, guess_valid, guess);
    end
  endtask

  task automatic test_filter();
    logic ov, rj;
    push(8'h61, ov, rj);
    checks++;
    if (rj !== 1'b0 || count !== 3'd1 || guess !== 8'h41) begin
      errors++;
      $display("FAIL filter_fold: rj=%b count=%0d guess=%h required 0 1 41", rj, count, guess);
    end
    push(8'h33, ov, rj);
    checks++;
    if (rj !== 1'b1 || ov !== 1'b0 || reject !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL filter_reject: pulse=%b ov=%b after=%b count=%0d required 1 0 0 1",
               rj, ov, reject, count);
    end
    push(8'h42, ov, rj);
    checks++;
    if (rj !== 1'b0 || count !== 3'd2 || guess !== 8'h41) begin
      errors++;
      $display("FAIL filter_upper: rj=%b count=%0d guess=%h required 0 2 41", rj, count, guess);
    end
    game_rdy = 1'b1;
    step();
    checks++;
    if (guess !== 8'h42 || count !== 3'd1) begin
      errors++;
      $display("FAIL filter_pop1: guess=%h count=%0d required 42 1", guess, count);
    end
    step();
    game_rdy = 1'b0;
    checks++;
    if (guess_valid !== 1'b0 || guess !== 8'h00 || count !== 3'd0) begin
      errors++;
      $display("FAIL filter_pop2: gv=%b guess=%h count=%0d required 0 00 0",
               guess_valid, guess, count);
    end
  endtask

  task automatic test_overflow();
    logic ov, rj;
    logic [7:0] in_b  [5];
    logic [7:0] exp_b [4];
    int ov_cnt;
    in_b  = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    exp_b = '{8'h41, 8'h42, 8'h43, 8'h44};
    ov_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      push(in_b[i], ov, rj);
      if (ov === 1'b1) ov_cnt++;
      if (i == 4) begin
        checks++;
        if (ov !== 1'b1) begin
          errors++;
          $display("FAIL overflow_5th: ov=%b required 1", ov);
        end
      end
    end
    checks++;
    if (ov_cnt != 1 || full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_state: pulses=%0d full=%b count=%0d ov_now=%b required 1 1 4 0",
               ov_cnt, full, count, overflow);
    end
    // Non-letter into a full FIFO: reject only
    push(8'h31, ov, rj);
    checks++;
    if (rj !== 1'b1 || ov !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL reject_priority: rj=%b ov=%b count=%0d required 1 0 4", rj, ov, count);
    end
    game_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (guess !== exp_b[i] || guess_valid !== 1'b1) begin
        errors++;
        $display("FAIL overflow_order[%0d]: guess=%h gv=%b required %h 1",
                 i, guess, guess_valid, exp_b[i]);
      end
      step();
    end
    game_rdy = 1'b0;
    checks++;
    if (guess_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL overflow_drain: gv=%b count=%0d required 0 0", guess_valid, count);
    end
  endtask

  task automatic test_full_push_pop();
    logic ov, rj;
    logic [7:0] exp_b [4];
    exp_b = '{8'h58, 8'h59, 8'h5A, 8'h51};
    push(8'h57, ov, rj);
    push(8'h58, ov, rj);
    push(8'h59, ov, rj);
    push(8'h5A, ov, rj);
    Rx_byte  = 8'h71;
    ready    = 1'b1;
    game_rdy = 1'b1;
    step();
    ready    = 1'b0;
    game_rdy = 1'b0;
    checks++;
    if (overflow !== 1'b0 || count !== 3'd4 || full !== 1'b1 || guess !== 8'h58) begin
      errors++;
      $display("FAIL full_push_pop: ov=%b count=%0d full=%b guess=%h required 0 4 1 58",
               overflow, count, full, guess);
    end
    step();
    game_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (guess !== exp_b[i]) begin
        errors++;
        $display("FAIL full_push_pop_order[%0d]: guess=%h required %h", i, guess, exp_b[i]);
      end
      step();
    end
    game_rdy = 1'b0;
  endtask

  task automatic test_flush();
    logic ov, rj;
    push(8'h61, ov, rj);
    push(8'h62, ov, rj);
    push(8'h63, ov, rj);
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre: count=%0d required 3", count);
    end
    Rx_byte = 8'h44;
    ready   = 1'b1;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    ready = 1'b0;
    checks++;
    if (count !== 3'd0 || guess !== 8'h00 || guess_valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: count=%0d guess=%h gv=%b full=%b required 0 00 0 0",
               count, guess, guess_valid, full);
    end
    step();
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL flush_push_dropped: count=%0d required 0", count);
    end
    push(8'h45, ov, rj);
    checks++;
    if (count !== 3'd1 || guess !== 8'h45) begin
      errors++;
      $display("FAIL flush_after_push: count=%0d guess=%h required 1 45", count, guess);
    end
    game_rdy = 1'b1;
    step();
    game_rdy = 1'b0;
  endtask

  task automatic test_wrap_async_reset();
    logic ov, rj;
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = 8'h4B + 8'(i);
      push(b, ov, rj);
      checks++;
      if (guess !== b || count !== 3'd1) begin
        errors++;
        $display("FAIL wrap[%0d]: guess=%h count=%0d required %h 1", i, guess, count, b);
      end
      game_rdy = 1'b1;
      step();
      game_rdy = 1'b0;
    end
    push(8'h41, ov, rj);
    push(8'h42, ov, rj);
    push(8'h43, ov, rj);
    push(8'h44, ov, rj);
    // Fifth push: sample right after its edge, with overflow high and full set
    Rx_byte = 8'h45;
    ready   = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (overflow !== 1'b1 || full !== 1'b1 || guess !== 8'h41) begin
      errors++;
      $display("FAIL wrap_prefill: ov=%b full=%b guess=%h required 1 1 41", overflow, full, guess);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || guess_valid !== 1'b0 || full !== 1'b0 ||
        guess !== 8'h00 || overflow !== 1'b0 || reject !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count=%0d gv=%b full=%b guess=%h ov=%b rj=%b required all 0",
               count, guess_valid, full, guess, overflow, reject);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_filter();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_wrap_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
